uart_rx_cfg: RTL and testbench

- Parametrised UART receiver and next-generation RX for the UART datapath; sits between the pad-side serial input and the RX FIFO/interface logic.
- Shares the oversampling tick source with the baud-rate generator.
- Adds over the first-generation receiver:
  - configurable data width and oversampling factor
  - runtime-selectable parity and 1 or 2 stop bits
  - input synchronisation and false-start rejection
  - parity and framing error flags, plus a one-cycle valid strobe

---
 rtl/uart_rx_cfg.sv | 196 +++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver with input synchroniser,
// false-start rejection, runtime parity (none/even/odd) and 1 or 2 stop bits.
// Results are published with a one-clk o_valid strobe. Parity and framing
// errors are flagged alongside the data word and never suppress it.
// Optional build macro UART_RX_MAJORITY_EN: every sample point becomes a
// 2-of-3 vote over the last three ticks leading up to the decision tick.
module uart_rx_cfg #(
  parameter int NB_DATA    = 8,
  parameter int OVERSAMPLE = 16,
  parameter int NB_SYNC    = 2
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_tick,
  input  logic               i_rx,
  input  logic [1:0]         i_parity_mode,
  input  logic               i_stop2,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_valid,
  output logic               o_parity_err,
  output logic               o_frame_err,
  output logic               o_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(NB_DATA + 1);
  localparam logic [TW-1:0] START_DEC = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] BIT_DEC   = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(NB_DATA - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t             r_state;
  logic [NB_SYNC-1:0] r_sync;
  logic [TW-1:0]      r_tick_cnt;
  logic [BW-1:0]      r_bit_cnt;
  logic [NB_DATA-1:0] r_shift;
  logic [1:0]         r_pmode;
  logic               r_stop2;
  logic               r_par_err;
  logic               r_frm_acc;
  logic [NB_DATA-1:0] r_data;
  logic               r_valid;
  logic               r_par_out;
  logic               r_frm_out;

  logic               w_rx_s;
  logic [TW-1:0]      w_dec_cnt;
  logic               w_dec_point;
  logic               w_bit;
  logic               w_par_en;
  logic               w_frm_now;

  // Bring the asynchronous line into the clk domain; idle level is 1.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= '1;
    else          r_sync <= {r_sync[NB_SYNC-2:0], i_rx};
  end

  assign w_rx_s      = r_sync[NB_SYNC-1];
  // The start check sits half a bit after the edge; every later sample is a
  // whole bit further on, which lands it at the centre of its bit.
  assign w_dec_cnt   = (r_state == S_START) ? START_DEC : BIT_DEC;
  assign w_dec_point = (r_tick_cnt == w_dec_cnt);
  assign w_par_en    = (r_pmode == 2'b01) || (r_pmode == 2'b10);
  assign w_frm_now   = r_frm_acc | ~w_bit;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] r_vote;

  // Capture the two ticks just before each decision tick for the vote.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vote <= 2'b11;
    end else if (i_tick && (r_state != S_IDLE)) begin
      if (r_tick_cnt == w_dec_cnt - TW'(2)) r_vote[0] <= w_rx_s;
      if (r_tick_cnt == w_dec_cnt - TW'(1)) r_vote[1] <= w_rx_s;
    end
  end

  assign w_bit = (r_vote[0] & r_vote[1]) | (r_vote[0] & w_rx_s) | (r_vote[1] & w_rx_s);
`else
  assign w_bit = w_rx_s;
`endif

  // Frame FSM: every transition clears the tick counter, so a tick that
  // coincides with a transition is absorbed rather than counted.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_pmode    <= 2'b00;
      r_stop2    <= 1'b0;
      r_par_err  <= 1'b0;
      r_frm_acc  <= 1'b0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_par_out  <= 1'b0;
      r_frm_out  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tick_cnt <= '0;
          r_bit_cnt  <= '0;
          if (!w_rx_s) begin
            r_state   <= S_START;
            r_pmode   <= i_parity_mode;
            r_stop2   <= i_stop2;
            r_par_err <= 1'b0;
            r_frm_acc <= 1'b0;
          end
        end
        S_START: begin
          if (i_tick) begin
            if (w_dec_point) begin
              r_tick_cnt <= '0;
              r_bit_cnt  <= '0;
              r_state    <= w_bit ? S_IDLE : S_DATA;
            end else begin
              r_tick_cnt <= r_tick_cnt + TW'(1);
            end
          end
        end
        S_DATA: begin
          if (i_tick) begin
            if (w_dec_point) begin
              r_tick_cnt <= '0;
              r_shift    <= {w_bit, r_shift[NB_DATA-1:1]};
              if (r_bit_cnt == LAST_BIT) begin
                r_bit_cnt <= '0;
                r_state   <= w_par_en ? S_PARITY : S_STOP;
              end else begin
                r_bit_cnt <= r_bit_cnt + BW'(1);
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + TW'(1);
            end
          end
        end
        S_PARITY: begin
          if (i_tick) begin
            if (w_dec_point) begin
              r_tick_cnt <= '0;
              // Even: error when the overall XOR is 1; odd: when it is 0.
              r_par_err  <= (^r_shift) ^ w_bit ^ (r_pmode == 2'b10);
              r_state    <= S_STOP;
            end else begin
              r_tick_cnt <= r_tick_cnt + TW'(1);
            end
          end
        end
        S_STOP: begin
          if (i_tick) begin
            if (w_dec_point) begin
              r_tick_cnt <= '0;
              if (r_stop2 && (r_bit_cnt == '0)) begin
                r_frm_acc <= w_frm_now;
                r_bit_cnt <= BW'(1);
              end else begin
                // Leave at the stop-bit centre so a back-to-back start edge is caught.
                r_bit_cnt <= '0;
                r_state   <= S_IDLE;
                r_valid   <= 1'b1;
                r_data    <= r_shift;
                r_par_out <= r_par_err;
                r_frm_out <= w_frm_now;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + TW'(1);
            end
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_tick_cnt <= '0;
        end
      endcase
    end
  end

  assign o_data       = r_data;
  assign o_valid      = r_valid;
  assign o_parity_err = r_par_out;
  assign o_frame_err  = r_frm_out;
  assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: directed frames from the test plan followed by
// randomised frames, checked against a frame-level reference model.
module tb_uart_rx_cfg;

  localparam int NB_DATA    = 8;
  localparam int OVERSAMPLE = 16;
  localparam int NB_SYNC    = 2;
  localparam int TDIV       = 3;
  localparam int BIT_CLK    = OVERSAMPLE * TDIV;

  typedef struct {
    logic [NB_DATA-1:0] d;
    logic               pe;
    logic               fe;
  } exp_t;

  logic               clk = 1'b0;
  logic               i_rst_n = 1'b0;
  logic               i_tick = 1'b0;
  logic               i_rx = 1'b1;
  logic [1:0]         i_parity_mode = 2'b00;
  logic               i_stop2 = 1'b0;
  logic [NB_DATA-1:0] o_data;
  logic               o_valid;
  logic               o_parity_err;
  logic               o_frame_err;
  logic               o_busy;

  int   n_cmp = 0;
  int   n_err = 0;
  int   n_valid = 0;
  int   n_sent = 0;
  int   tdiv = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  uart_rx_cfg #(
    .NB_DATA(NB_DATA),
    .OVERSAMPLE(OVERSAMPLE),
    .NB_SYNC(NB_SYNC)
  ) dut (
    .clk(clk),
    .i_rst_n(i_rst_n),
    .i_tick(i_tick),
    .i_rx(i_rx),
    .i_parity_mode(i_parity_mode),
    .i_stop2(i_stop2),
    .o_data(o_data),
    .o_valid(o_valid),
    .o_parity_err(o_parity_err),
    .o_frame_err(o_frame_err),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  // One-clk tick every TDIV clocks.
  always @(posedge clk) begin
    tdiv   <= (tdiv == TDIV - 1) ? 0 : tdiv + 1;
    i_tick <= (tdiv == TDIV - 1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: what a correct receiver reports for a frame, from its bits.
  function automatic exp_t model(input logic [NB_DATA-1:0] d, input logic [1:0] pm,
                                 input logic st2, input logic pb, input logic sa, input logic sb);
    exp_t e;
    int   ones;
    ones = $countones(d) + int'(pb);
    e.d  = d;
    if (pm == 2'b01)      e.pe = (ones % 2) != 0;
    else if (pm == 2'b10) e.pe = (ones % 2) == 0;
    else                  e.pe = 1'b0;
    e.fe = !sa || (st2 && !sb);
    return e;
  endfunction

  // Scoreboard: every strobe must match the oldest outstanding frame.
  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      n_valid++;
      chk("valid_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        $display("rx frame %0d: data=0x%0h perr=%0b ferr=%0b (model 0x%0h %0b %0b)",
                 n_valid, o_data, o_parity_err, o_frame_err, mon_e.d, mon_e.pe, mon_e.fe);
        chk("data", 32'(o_data), 32'(mon_e.d));
        chk("parity_err", 32'(o_parity_err), 32'(mon_e.pe));
        chk("frame_err", 32'(o_frame_err), 32'(mon_e.fe));
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b, input int n);
    i_rx = b;
    wait_clk(n);
  endtask

  task automatic send_frame(input logic [NB_DATA-1:0] d, input logic [1:0] pm, input logic st2,
                            input logic pb, input logic sa, input logic sb, input int gap,
                            input int glitch_idx);
    logic fin;
    exp_q.push_back(model(d, pm, st2, pb, sa, sb));
    n_sent++;
    i_parity_mode = pm;
    i_stop2       = st2;
    drive_bit(1'b0, BIT_CLK);
    for (int i = 0; i < NB_DATA; i++) begin
      if (glitch_idx == i) begin
        drive_bit(d[i], BIT_CLK / 2);
        drive_bit(~d[i], TDIV);
        drive_bit(d[i], BIT_CLK / 2 - TDIV);
      end else begin
        drive_bit(d[i], BIT_CLK);
      end
      // Configuration is captured at the start edge; disturb it mid-frame.
      if (i == 0) begin
        i_parity_mode = 2'($urandom_range(3));
        i_stop2       = 1'($urandom_range(1));
      end
    end
    if (pm == 2'b01 || pm == 2'b10) drive_bit(pb, BIT_CLK);
    if (st2) begin
      drive_bit(sa, BIT_CLK);
      fin = sb;
    end else begin
      fin = sa;
    end
    // A low final stop bit releases early so the receiver's re-armed start
    // check sees an idle line rather than a phantom start bit.
    if (fin) begin
      drive_bit(1'b1, BIT_CLK);
    end else begin
      drive_bit(1'b0, BIT_CLK * 3 / 4);
      drive_bit(1'b1, BIT_CLK / 4);
    end
    drive_bit(1'b1, gap);
  endtask

  initial begin
    logic [NB_DATA-1:0] rd;
    logic [1:0]         rpm;
    logic               rst2, rpb, rsa, rsb, rfin;
    int                 rgap;

    // Reset state
    wait_clk(4);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_perr", 32'(o_parity_err), 32'd0);
    chk("rst_ferr", 32'(o_frame_err), 32'd0);
    i_rst_n = 1'b1;
    wait_clk(2 * BIT_CLK);
    chk("idle_busy", 32'(o_busy), 32'd0);

    // 8N1 0xA5, with busy observed mid-frame and cleared afterwards
    fork
      send_frame(8'hA5, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 2 * BIT_CLK, -1);
      begin
        wait_clk(3 * BIT_CLK);
        chk("busy_mid_frame", 32'(o_busy), 32'd1);
      end
    join
    chk("busy_after_frame", 32'(o_busy), 32'd0);
    chk("count_a5", 32'(n_valid), 32'(n_sent));
    chk("hold_a5", 32'(o_data), 32'h A5);

    // Even parity, correct then wrong parity bit
    send_frame(8'h3C, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, BIT_CLK, -1);
    send_frame(8'h3C, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, BIT_CLK, -1);
    chk("count_even", 32'(n_valid), 32'(n_sent));
    chk("hold_perr", 32'(o_parity_err), 32'd1);

    // Odd parity, two stop bits, second stop low
    send_frame(8'h81, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 3 * BIT_CLK, -1);
    chk("count_odd", 32'(n_valid), 32'(n_sent));

    // Short low glitch on idle line must be rejected
    drive_bit(1'b0, 4 * TDIV);
    drive_bit(1'b1, 2 * BIT_CLK);
    chk("glitch_no_valid", 32'(n_valid), 32'(n_sent));
    chk("glitch_idle", 32'(o_busy), 32'd0);
    send_frame(8'h55, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, BIT_CLK, -1);
    chk("count_55", 32'(n_valid), 32'(n_sent));

    // Back-to-back frames with no idle gap
    send_frame(8'h12, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 0, -1);
    send_frame(8'h34, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 2 * BIT_CLK, -1);
    chk("count_b2b", 32'(n_valid), 32'(n_sent));

    // Reset in the middle of a 0xFF frame discards it
    i_parity_mode = 2'b00;
    i_stop2       = 1'b0;
    drive_bit(1'b0, BIT_CLK);
    drive_bit(1'b1, 3 * BIT_CLK);
    chk("busy_before_abort", 32'(o_busy), 32'd1);
    i_rst_n = 1'b0;
    #1;
    chk("abort_busy_async", 32'(o_busy), 32'd0);
    chk("abort_data_cleared", 32'(o_data), 32'd0);
    wait_clk(5);
    i_rst_n = 1'b1;
    drive_bit(1'b1, 7 * BIT_CLK);
    chk("abort_no_valid", 32'(n_valid), 32'(n_sent));
    send_frame(8'h0F, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, BIT_CLK, -1);
    chk("count_0f", 32'(n_valid), 32'(n_sent));

`ifdef UART_RX_MAJORITY_EN
    // Single-tick inverted pulse at a data-bit centre is voted out
    send_frame(8'h6B, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, BIT_CLK, 3);
    chk("count_majority", 32'(n_valid), 32'(n_sent));
`endif

    // Randomised frames
    for (int k = 0; k < 40; k++) begin
      rd   = NB_DATA'($urandom);
      rpm  = 2'($urandom_range(3));
      rst2 = 1'($urandom_range(1));
      rpb  = 1'($urandom_range(1));
      rsa  = ($urandom_range(5) != 0);
      rsb  = ($urandom_range(5) != 0);
      rfin = rst2 ? rsb : rsa;
      if (!rfin)                      rgap = 2 * BIT_CLK;
      else if ($urandom_range(1) == 0) rgap = 0;
      else                            rgap = $urandom_range(2 * BIT_CLK);
      send_frame(rd, rpm, rst2, rpb, rsa, rsb, rgap, -1);
    end

    wait_clk(3 * BIT_CLK);
    chk("final_count", 32'(n_valid), 32'(n_sent));
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("final_idle", 32'(o_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
